aq_vidu_vid_fp_opd_buf: RTL

// - Parametrised successor of the VIDU FP dispatch datapath.
// - Muxes FGPR read data against N forward buses and captures each FP/vector-scalar instruction in a DEPTH-entry FIFO.
// - Issues to VPU with valid/ready handshake; with VIDU_FP_SRC2_WAKEUP_EN, entries snoop forward buses until srcf2 is ready.
// - Sits between VIDU FP dispatch control and VPU FP issue port.

---
 rtl/aq_vidu_fp_pkg.sv | 26 ++
 rtl/aq_vidu_fp_fwd_sel.sv | 31 +++
 rtl/aq_vidu_vid_fp_opd_buf_chk.sv | 15 +
 rtl/aq_vidu_vid_fp_opd_buf.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/aq_vidu_fp_pkg.sv
// Shared types and default widths for the VIDU FP operand buffer slice.
package aq_vidu_fp_pkg;

    localparam int FP_DATA_W  = 64;
    localparam int FP_REG_W   = 5;
    localparam int FP_NUM_FWD = 2;
    localparam int FP_DEPTH   = 2;
    localparam int FP_FUNC_W  = 20;
    localparam int FP_EU_W    = 10;

    typedef struct packed {
        logic [FP_FUNC_W-1:0]            func;
        logic [FP_EU_W-1:0]              eu;
        logic                            dstf_vld;
        logic [FP_REG_W-1:0]             dstf_reg;
        logic                            srcf2_vld;
        logic [FP_REG_W-1:0]             srcf2_reg;
        logic                            srcf2_rdy;
        logic [2:0][FP_DATA_W-1:0]       data;
    } fp_opd_entry_t;

    function automatic int fp_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/aq_vidu_fp_fwd_sel.sv
// Priority forward match: the lowest-index valid channel whose index equals src_reg supplies data.
module aq_vidu_fp_fwd_sel
    import aq_vidu_fp_pkg::*;
#(
    parameter int DATA_W  = FP_DATA_W,
    parameter int REG_W   = FP_REG_W,
    parameter int NUM_FWD = FP_NUM_FWD
) (
    input  logic [REG_W-1:0]          src_reg,
    input  logic [NUM_FWD-1:0]        fwd_vld,
    input  logic [NUM_FWD*REG_W-1:0]  fwd_reg,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic                      hit,
    output logic [DATA_W-1:0]         data
);

    logic match_s;

    // Scan from the last channel down so that channel 0 overrides everything else.
    always_comb begin
        hit     = 1'b0;
        data    = {DATA_W{1'b0}};
        match_s = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            match_s = fwd_vld[k] && (fwd_reg[k*REG_W +: REG_W] == src_reg);
            data    = match_s ? fwd_data[k*DATA_W +: DATA_W] : data;
            hit     = hit | match_s;
        end
    end

endmodule

// File: rtl/aq_vidu_vid_fp_opd_buf_chk.sv
// Protocol checks for the FP operand buffer occupancy and issue handshake.
module aq_vidu_vid_fp_opd_buf_chk #(
    parameter int CNT_W = 2,
    parameter int DEPTH = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             pop,
    input logic [CNT_W-1:0] cnt
);

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> (cnt != {CNT_W{1'b0}}));
    a_cnt_bound:    assert property (@(posedge clk) disable iff (!rst_n) cnt <= CNT_W'(DEPTH));

endmodule

// File: rtl/aq_vidu_vid_fp_opd_buf.sv
// FP dispatch operand buffer: forward-muxed capture into a FIFO issuing to the VPU.
// Optional srcf2 wakeup snooping is enabled by defining VIDU_FP_SRC2_WAKEUP_EN.
module aq_vidu_vid_fp_opd_buf
    import aq_vidu_fp_pkg::*;
#(
    parameter int DATA_W  = FP_DATA_W,
    parameter int REG_W   = FP_REG_W,
    parameter int NUM_FWD = FP_NUM_FWD,
    parameter int DEPTH   = FP_DEPTH,
    parameter int FUNC_W  = FP_FUNC_W,
    parameter int EU_W    = FP_EU_W
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst_b,
    input  logic                      vidu_flush,
    input  logic                      dis_vld,
    output logic                      dis_rdy,
    input  logic [FUNC_W-1:0]         dis_func,
    input  logic [EU_W-1:0]           dis_eu,
    input  logic                      dis_dstf_vld,
    input  logic [REG_W-1:0]          dis_dstf_reg,
    input  logic [2:0]                dis_srcf_vld,
    input  logic [3*REG_W-1:0]        dis_srcf_reg,
    input  logic [3*DATA_W-1:0]       gpr_src_data,
    input  logic                      wbt_srcf2_rdy,
    input  logic [NUM_FWD-1:0]        fwd_vld,
    input  logic [NUM_FWD*REG_W-1:0]  fwd_reg,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic                      vpu_out_vld,
    input  logic                      vpu_out_rdy,
    output logic [FUNC_W-1:0]         vpu_out_func,
    output logic [EU_W-1:0]           vpu_out_eu,
    output logic                      vpu_out_dstf_vld,
    output logic [REG_W-1:0]          vpu_out_dstf_reg,
    output logic [3*DATA_W-1:0]       vpu_out_srcf_data,
    output logic                      vpu_out_srcf2_rdy,
    output logic [$clog2(DEPTH):0]    buf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = fp_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DEPTH-1:0]    vld_r, dstf_vld_r, srcf2_rdy_r;
    logic [FUNC_W-1:0]   func_r [DEPTH];
    logic [EU_W-1:0]     eu_r [DEPTH];
    logic [REG_W-1:0]    dstf_reg_r [DEPTH];
    logic [3*DATA_W-1:0] data_r [DEPTH];

    logic [2:0]          hit_s;
    logic [3*DATA_W-1:0] fwd_opd_s, opd_s;
    logic                srcf2_rdy_in_s, push_s, pop_s, head_rdy_s;
    logic [DEPTH-1:0]    wake_s;
    logic [DATA_W-1:0]   wk_data_s [DEPTH];

    for (genvar i = 0; i < 3; i++) begin : g_dis_sel
        aq_vidu_fp_fwd_sel #(.DATA_W(DATA_W), .REG_W(REG_W), .NUM_FWD(NUM_FWD)) u_sel (
            .src_reg  (dis_srcf_reg[i*REG_W +: REG_W]),
            .fwd_vld  (fwd_vld),
            .fwd_reg  (fwd_reg),
            .fwd_data (fwd_data),
            .hit      (hit_s[i]),
            .data     (fwd_opd_s[i*DATA_W +: DATA_W])
        );
        assign opd_s[i*DATA_W +: DATA_W] = hit_s[i] ? fwd_opd_s[i*DATA_W +: DATA_W]
                                                    : gpr_src_data[i*DATA_W +: DATA_W];
    end

    assign srcf2_rdy_in_s = ~dis_srcf_vld[2] | wbt_srcf2_rdy | hit_s[2];

`ifdef VIDU_FP_SRC2_WAKEUP_EN
    logic [REG_W-1:0] srcf2_reg_r [DEPTH];
    logic [DEPTH-1:0] wk_hit_s;

    for (genvar e = 0; e < DEPTH; e++) begin : g_wk_sel
        aq_vidu_fp_fwd_sel #(.DATA_W(DATA_W), .REG_W(REG_W), .NUM_FWD(NUM_FWD)) u_sel (
            .src_reg  (srcf2_reg_r[e]),
            .fwd_vld  (fwd_vld),
            .fwd_reg  (fwd_reg),
            .fwd_data (fwd_data),
            .hit      (wk_hit_s[e]),
            .data     (wk_data_s[e])
        );
    end
    // An entry whose srcf2 is already ready never snoops again.
    assign wake_s     = wk_hit_s & vld_r & ~srcf2_rdy_r;
    assign head_rdy_s = srcf2_rdy_r[rd_ptr_r];
`else
    for (genvar e = 0; e < DEPTH; e++) begin : g_wk_off
        assign wk_data_s[e] = {DATA_W{1'b0}};
    end
    assign wake_s     = {DEPTH{1'b0}};
    assign head_rdy_s = 1'b1;
`endif

    assign dis_rdy = (cnt_r != DEPTH_CNT);
    assign push_s  = dis_vld & dis_rdy;
    assign pop_s   = vpu_out_vld & vpu_out_rdy;

    // Pointer and occupancy update; flush acts as a synchronous clear that beats push/pop.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (vidu_flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Entry storage: push writes the tail slot, pop frees the head, wakeup patches srcf2 in place.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld_r       <= {DEPTH{1'b0}};
            dstf_vld_r  <= {DEPTH{1'b0}};
            srcf2_rdy_r <= {DEPTH{1'b0}};
            for (int e = 0; e < DEPTH; e++) begin
                func_r[e]     <= {FUNC_W{1'b0}};
                eu_r[e]       <= {EU_W{1'b0}};
                dstf_reg_r[e] <= {REG_W{1'b0}};
                data_r[e]     <= {(3*DATA_W){1'b0}};
`ifdef VIDU_FP_SRC2_WAKEUP_EN
                srcf2_reg_r[e] <= {REG_W{1'b0}};
`endif
            end
        end else if (vidu_flush) begin
            vld_r <= {DEPTH{1'b0}};
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (push_s && (wr_ptr_r == PTR_W'(e))) begin
                    vld_r[e]       <= 1'b1;
                    func_r[e]      <= dis_func;
                    eu_r[e]        <= dis_eu;
                    dstf_vld_r[e]  <= dis_dstf_vld;
                    dstf_reg_r[e]  <= dis_dstf_reg;
                    srcf2_rdy_r[e] <= srcf2_rdy_in_s;
                    data_r[e]      <= opd_s;
`ifdef VIDU_FP_SRC2_WAKEUP_EN
                    srcf2_reg_r[e] <= dis_srcf_reg[2*REG_W +: REG_W];
`endif
                end else if (pop_s && (rd_ptr_r == PTR_W'(e))) begin
                    vld_r[e] <= 1'b0;
                end else if (wake_s[e]) begin
                    srcf2_rdy_r[e]                    <= 1'b1;
                    data_r[e][2*DATA_W +: DATA_W]     <= wk_data_s[e];
                end else begin
                    vld_r[e] <= vld_r[e];
                end
            end
        end
    end

    assign vpu_out_vld       = vld_r[rd_ptr_r] & head_rdy_s;
    assign vpu_out_func      = func_r[rd_ptr_r];
    assign vpu_out_eu        = eu_r[rd_ptr_r];
    assign vpu_out_dstf_vld  = dstf_vld_r[rd_ptr_r];
    assign vpu_out_dstf_reg  = dstf_reg_r[rd_ptr_r];
    assign vpu_out_srcf_data = data_r[rd_ptr_r];
    assign vpu_out_srcf2_rdy = srcf2_rdy_r[rd_ptr_r];
    assign buf_cnt           = cnt_r;

    aq_vidu_vid_fp_opd_buf_chk #(.CNT_W(CNT_W), .DEPTH(DEPTH)) u_chk (
        .clk   (forever_cpuclk),
        .rst_n (cpurst_b),
        .pop   (pop_s),
        .cnt   (cnt_r)
    );

endmodule
